// File: rtl/winograd_filter_3x3_transform.sv
// Winograd F(2x2,3x3) filter transform: U = G*g*G^T on a 3x3 signed 8-bit kernel.
// Two-stage pipeline: column pass into stage-1 registers, row pass + floor/saturate into the output.
module winograd_filter_3x3_transform (
    input  logic         clk,
    input  logic         rstn,
    input  logic [71:0]  filter,
    output logic [127:0] filter_transformed
);

    localparam int DATA_W = 8;
    localparam int T_W    = 10;
    localparam int V_W    = 12;

    localparam logic signed [V_W-1:0] SAT_MAX = 12'sd127;
    localparam logic signed [V_W-1:0] SAT_MIN = -12'sd128;

    // V is computed with G' = 2G, so dividing by 4 (floor) restores the true scale.
    function automatic logic signed [DATA_W-1:0] floor_sat(input logic signed [V_W-1:0] v);
        logic signed [V_W-1:0] s;
        s = v >>> 2;
        if (s > SAT_MAX) begin
            return 8'sh7F;
        end else if (s < SAT_MIN) begin
            return -8'sh80;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    logic signed [T_W-1:0] g_ext [3][3];
    logic signed [T_W-1:0] t_c   [4][3];
    logic signed [T_W-1:0] t_p1  [4][3];
    logic signed [V_W-1:0] t_ext [4][3];
    logic signed [V_W-1:0] v_c   [4][4];
    logic [127:0]          u_c;

    // Stage 1: column pass T = G' * g
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                g_ext[r][c] = T_W'($signed(filter[71-8*(3*r+c) -: 8]));
            end
        end
        for (int c = 0; c < 3; c++) begin
            t_c[0][c] = g_ext[0][c] + g_ext[0][c];
            t_c[1][c] = g_ext[0][c] + g_ext[1][c] + g_ext[2][c];
            t_c[2][c] = g_ext[0][c] - g_ext[1][c] + g_ext[2][c];
            t_c[3][c] = g_ext[2][c] + g_ext[2][c];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            t_p1 <= '{default: '0};
        end else begin
            t_p1 <= t_c;
        end
    end

    // Stage 2: row pass V = T * G'^T, then floor/saturate into the output register
    always_comb begin
        u_c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                t_ext[i][k] = V_W'(t_p1[i][k]);
            end
            v_c[i][0] = t_ext[i][0] + t_ext[i][0];
            v_c[i][1] = t_ext[i][0] + t_ext[i][1] + t_ext[i][2];
            v_c[i][2] = t_ext[i][0] - t_ext[i][1] + t_ext[i][2];
            v_c[i][3] = t_ext[i][2] + t_ext[i][2];
            for (int j = 0; j < 4; j++) begin
                u_c[127-8*(4*i+j) -: 8] = floor_sat(v_c[i][j]);
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            filter_transformed <= '0;
        end else begin
            filter_transformed <= u_c;
        end
    end

endmodule

// File: tb/tb_winograd_filter_3x3_transform.sv
// Scoreboard bench for winograd_filter_3x3_transform: expected outputs queued at drive time,
// popped two edges later; reset and asynchronous mid-run reset behaviour checked directly.
module tb_winograd_filter_3x3_transform;

    logic         clk;
    logic         rstn;
    logic [71:0]  filter;
    logic [127:0] filter_transformed;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q [$];

    localparam logic [71:0]  NOM_IN  = 72'h040404060606080808;
    localparam logic [127:0] NOM_OUT = 128'h04060204_090D0409_03040103_080C0408;
    localparam logic [71:0]  IMP_IN  = 72'h010000000000000000;
    localparam logic [127:0] IMP_OUT = 128'h01000000_00000000_00000000_00000000;
    localparam logic [71:0]  NEG_IN  = 72'h808080808080808080;
    localparam logic [127:0] NEG_OUT = 128'h8080C080_8080A080_C0A0E0C0_8080C080;
    localparam logic [71:0]  POS_IN  = 72'h7F7F7F7F7F7F7F7F7F;
    localparam logic [127:0] POS_OUT = 128'h7F7F3F7F_7F7F5F7F_3F5F1F3F_7F7F3F7F;

    winograd_filter_3x3_transform dut (
        .clk                (clk),
        .rstn               (rstn),
        .filter             (filter),
        .filter_transformed (filter_transformed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: full matrix product with G' = 2G, floor divide by 4, clamp to 8 bits.
    function automatic logic [127:0] model(input logic [71:0] f);
        int gp [4][3];
        int g  [3][3];
        int v;
        int u;
        logic [127:0] res;
        gp[0][0] = 2; gp[0][1] = 0;  gp[0][2] = 0;
        gp[1][0] = 1; gp[1][1] = 1;  gp[1][2] = 1;
        gp[2][0] = 1; gp[2][1] = -1; gp[2][2] = 1;
        gp[3][0] = 0; gp[3][1] = 0;  gp[3][2] = 2;
        res = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[r][c] = int'($signed(f[71-8*(3*r+c) -: 8]));
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = 0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        v += gp[i][a] * g[a][b] * gp[j][b];
                u = v >>> 2;
                if (u > 127) u = 127;
                if (u < -128) u = -128;
                res[127-8*(4*i+j) -: 8] = u[7:0];
            end
        end
        return res;
    endfunction

    // One clock: drive f, queue its expected result, compare whatever has reached the output.
    task automatic cycle(input string tag, input logic [71:0] f, input logic [127:0] exp);
        filter = f;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            check(tag, filter_transformed, exp_q.pop_front());
        end else begin
            check("prime_zero", filter_transformed, 128'h0);
        end
    endtask

    initial begin
        logic [71:0] f;

        rstn   = 1'b1;
        filter = NOM_IN;
        #1;
        check("reset_async_t0", filter_transformed, 128'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", filter_transformed, 128'h0);
        end
        rstn = 1'b0;

        cycle("nominal", NOM_IN, NOM_OUT);
        cycle("nominal", NOM_IN, NOM_OUT);
        cycle("impulse", IMP_IN, IMP_OUT);
        cycle("neg_sat", NEG_IN, NEG_OUT);
        cycle("pos_sat", POS_IN, POS_OUT);
        cycle("pos_sat", POS_IN, POS_OUT);

        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) cycle("alt_nom", NOM_IN, NOM_OUT);
            else            cycle("alt_zero", 72'h0, 128'h0);
        end

        cycle("mixed_a", 72'h7F807F807F807F807F, model(72'h7F807F807F807F807F));
        cycle("mixed_b", 72'h80807F7F7F7F808080, model(72'h80807F7F7F7F808080));
        cycle("mixed_c", 72'hFF01FF01FF01FF01FF, model(72'hFF01FF01FF01FF01FF));

        for (int k = 0; k < 24; k++) begin
            f[31:0]  = $urandom();
            f[63:32] = $urandom();
            f[71:64] = 8'($urandom());
            cycle("random", f, model(f));
        end

        cycle("pre_reset", NOM_IN, NOM_OUT);
        cycle("pre_reset", NOM_IN, NOM_OUT);
        check("pre_reset_nonzero", filter_transformed, NOM_OUT);

        // Asynchronous reset between edges: output must clear without a clock edge.
        #2;
        rstn = 1'b1;
        #1;
        check("midrun_async_clear", filter_transformed, 128'h0);
        #3;
        check("midrun_hold", filter_transformed, 128'h0);
        rstn = 1'b0;
        exp_q.delete();

        cycle("after_release", IMP_IN, IMP_OUT);
        cycle("after_release", IMP_IN, IMP_OUT);
        cycle("after_release_neg", NEG_IN, NEG_OUT);
        cycle("flush", 72'h0, 128'h0);
        cycle("flush", 72'h0, 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
